// File: rtl/blit_bus_seq.sv
// blit_bus_seq: blitter bus-cycle sequencer issuing source-read, dest-read and dest-write memory cycles per pixel-word.
module blit_bus_seq #(
  parameter int CW = 16
) (
  input  logic          sys_clk,
  input  logic          xreset_n,
  input  logic          go,
  input  logic          src_en,
  input  logic          dsten,
  input  logic          busprio,
  input  logic [3:0]    cmd_width,
  input  logic [CW-1:0] count,
  input  logic          int_clr,
  input  logic          blit_back,
  input  logic          ack,
  output logic          blit_breq_0,
  output logic          blit_breq_1,
  output logic          mreq,
  output logic          read,
  output logic          width_0,
  output logic          width_1,
  output logic          width_2,
  output logic          width_3,
  output logic [1:0]    phase,
  output logic          step_s,
  output logic          step_d,
  output logic          busy,
  output logic          blit_int
);
  typedef enum logic [2:0] {IDLE, REQ, ISSUE, WAIT, DONE} state_t;
  state_t st, st_n;
  logic [1:0] ph, ph_n, first, nxt;
  logic [CW-1:0] cnt, cnt_n;
  logic se, de, bp, acc, busy_n, act_n;
  logic [3:0] wd;
  assign {width_3, width_2, width_1, width_0} = wd;
  always_comb begin
    acc = st == IDLE && !busy && go;
    first = se ? 2'd1 : de ? 2'd2 : 2'd3;
    nxt = ph == 2'd1 ? (de ? 2'd2 : 2'd3) : ph == 2'd2 ? 2'd3 : first;
    st_n = st;
    ph_n = ph;
    cnt_n = cnt;
    busy_n = busy;
    case (st)
      // a zero-count command lingers one cycle in IDLE with busy set before DONE
      IDLE: if (busy) st_n = DONE;
        else if (acc) begin
          cnt_n = count;
          ph_n = src_en ? 2'd1 : dsten ? 2'd2 : 2'd3;
          st_n = count != '0 ? REQ : IDLE;
          busy_n = 1'b1;
        end
      REQ: st_n = blit_back ? ISSUE : REQ;
      ISSUE: st_n = WAIT;
      WAIT: if (ack) begin
          ph_n = nxt;
          cnt_n = ph == 2'd3 ? cnt - CW'(1) : cnt;
          st_n = ph == 2'd3 && cnt_n == '0 ? DONE : blit_back ? ISSUE : REQ;
        end
      DONE: begin
          st_n = IDLE;
          busy_n = 1'b0;
        end
      default: st_n = IDLE;
    endcase
    act_n = st_n == REQ || st_n == ISSUE || st_n == WAIT;
  end
  always_ff @(posedge sys_clk) begin
    if (!xreset_n) begin
      st <= IDLE;
      ph <= '0;
      cnt <= '0;
      {se, de, bp, wd} <= '0;
      {blit_breq_0, blit_breq_1, mreq, read, phase, step_s, step_d, busy, blit_int} <= '0;
    end else begin
      st <= st_n;
      ph <= ph_n;
      cnt <= cnt_n;
      busy <= busy_n;
      if (acc) {se, de, bp, wd} <= {src_en, dsten, busprio, cmd_width};
      blit_breq_0 <= act_n;
      blit_breq_1 <= act_n && (acc ? busprio : bp);
      mreq <= st_n == ISSUE;
      read <= (st_n == ISSUE || st_n == WAIT) && ph_n != 2'd3;
      phase <= act_n ? ph_n : 2'd0;
      step_s <= st == WAIT && ack && ph == 2'd1;
      step_d <= st == WAIT && ack && ph == 2'd3;
      blit_int <= st == DONE || (blit_int && !int_clr);
    end
  end
endmodule

// File: tb/tb_blit_bus_seq.sv
// tb_blit_bus_seq: directed vector table plus hand-written corner sequences for blit_bus_seq.
module tb_blit_bus_seq;
  logic sys_clk, xreset_n, go, src_en, dsten, busprio, int_clr, blit_back, ack;
  logic [3:0] cmd_width;
  logic [15:0] count;
  logic blit_breq_0, blit_breq_1, mreq, read, w0, w1, w2, w3, step_s, step_d, busy, blit_int;
  logic [1:0] phase;
  logic [9:0] o;
  logic [3:0] wv;
  int total = 0, bad = 0, nd;
  assign o = {blit_breq_0, blit_breq_1, mreq, read, phase, step_s, step_d, busy, blit_int};
  assign wv = {w3, w2, w1, w0};
  blit_bus_seq #(.CW(16)) dut (
    .sys_clk(sys_clk), .xreset_n(xreset_n), .go(go), .src_en(src_en), .dsten(dsten),
    .busprio(busprio), .cmd_width(cmd_width), .count(count), .int_clr(int_clr),
    .blit_back(blit_back), .ack(ack), .blit_breq_0(blit_breq_0), .blit_breq_1(blit_breq_1),
    .mreq(mreq), .read(read), .width_0(w0), .width_1(w1), .width_2(w2), .width_3(w3),
    .phase(phase), .step_s(step_s), .step_d(step_d), .busy(busy), .blit_int(blit_int)
  );
  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;
  typedef struct {
    logic go, se, de, bp;
    logic [15:0] cnt;
    logic back, ack, clr;
    logic [9:0] exp;
  } vec_t;
  vec_t v[22];
  task automatic tick;
    @(posedge sys_clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic wait_idle(input string nm);
    for (int i = 0; i < 60 && busy; i++) tick;
    chk(nm, busy, 0);
  endtask
  task automatic clear_int;
    int_clr = 1;
    tick;
    int_clr = 0;
  endtask
  initial begin
    // exp = {breq0, breq1, mreq, read, phase[1:0], step_s, step_d, busy, blit_int}
    v[0]  = '{1, 1, 0, 0, 16'd2, 1, 0, 0, 10'b1_0_0_0_01_0_0_1_0};
    v[1]  = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_0_1_1_01_0_0_1_0};
    v[2]  = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_0_0_1_01_0_0_1_0};
    v[3]  = '{0, 0, 0, 0, 16'd0, 1, 1, 0, 10'b1_0_1_0_11_1_0_1_0};
    v[4]  = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_0_0_0_11_0_0_1_0};
    v[5]  = '{0, 0, 0, 0, 16'd0, 1, 1, 0, 10'b1_0_1_1_01_0_1_1_0};
    v[6]  = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_0_0_1_01_0_0_1_0};
    v[7]  = '{0, 0, 0, 0, 16'd0, 1, 1, 0, 10'b1_0_1_0_11_1_0_1_0};
    v[8]  = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_0_0_0_11_0_0_1_0};
    v[9]  = '{0, 0, 0, 0, 16'd0, 1, 1, 0, 10'b0_0_0_0_00_0_1_1_0};
    v[10] = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b0_0_0_0_00_0_0_0_1};
    v[11] = '{0, 0, 0, 0, 16'd0, 1, 0, 1, 10'b0_0_0_0_00_0_0_0_0};
    v[12] = '{1, 1, 1, 1, 16'd1, 1, 0, 0, 10'b1_1_0_0_01_0_0_1_0};
    v[13] = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_1_1_1_01_0_0_1_0};
    v[14] = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_1_0_1_01_0_0_1_0};
    v[15] = '{0, 0, 0, 0, 16'd0, 1, 1, 0, 10'b1_1_1_1_10_1_0_1_0};
    v[16] = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_1_0_1_10_0_0_1_0};
    v[17] = '{0, 0, 0, 0, 16'd0, 1, 1, 0, 10'b1_1_1_0_11_0_0_1_0};
    v[18] = '{0, 0, 0, 0, 16'd0, 1, 0, 0, 10'b1_1_0_0_11_0_0_1_0};
    v[19] = '{0, 0, 0, 0, 16'd0, 1, 1, 0, 10'b0_0_0_0_00_0_1_1_0};
    v[20] = '{0, 0, 0, 0, 16'd0, 1, 0, 1, 10'b0_0_0_0_00_0_0_0_1};
    v[21] = '{0, 0, 0, 0, 16'd0, 1, 0, 1, 10'b0_0_0_0_00_0_0_0_0};
    {go, src_en, dsten, busprio, int_clr, blit_back, ack} = '0;
    cmd_width = 4'hA;
    count = '0;
    xreset_n = 0;
    tick;
    tick;
    chk("reset", {wv, o}, 0);
    xreset_n = 1;
    for (int i = 0; i < 22; i++) begin
      {go, src_en, dsten, busprio, count} = {v[i].go, v[i].se, v[i].de, v[i].bp, v[i].cnt};
      {blit_back, ack, int_clr} = {v[i].back, v[i].ack, v[i].clr};
      tick;
      chk($sformatf("row%0d", i), o, v[i].exp);
    end
    {go, src_en, dsten, busprio, int_clr, blit_back, ack} = '0;
    chk("width", wv, 4'hA);
    // grant withheld, then dropped during WAIT
    go = 1; count = 2;
    tick;
    go = 0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold%0d", i), {blit_breq_0, mreq}, 2'b10);
      if (i < 4) tick;
    end
    blit_back = 1;
    tick;
    chk("back_rise", mreq, 1);
    blit_back = 0;
    tick;
    chk("wait_noback", {mreq, phase}, 3'b011);
    ack = 1;
    tick;
    ack = 0;
    chk("ack_noback", {step_d, mreq, blit_breq_0}, 3'b101);
    tick;
    chk("req_hold0", mreq, 0);
    tick;
    chk("req_hold1", mreq, 0);
    blit_back = 1;
    tick;
    chk("back_again", mreq, 1);
    ack = 1;
    wait_idle("idle_a");
    ack = 0; blit_back = 0;
    clear_int;
    // zero count
    go = 1; count = 0;
    tick;
    go = 0;
    chk("zero1", {blit_breq_0, mreq, busy, blit_int}, 4'b0010);
    tick;
    chk("zero2", {blit_breq_0, mreq, busy, blit_int}, 4'b0010);
    tick;
    chk("zero3", {blit_breq_0, mreq, busy, blit_int}, 4'b0001);
    clear_int;
    // go while busy is ignored
    go = 1; count = 3; cmd_width = 4'h3;
    tick;
    go = 0;
    tick;
    go = 1; src_en = 1; count = 7; cmd_width = 4'hC;
    tick;
    go = 0; src_en = 0;
    chk("ign_w", wv, 4'h3);
    chk("ign_ph", phase, 3);
    blit_back = 1; ack = 1; nd = 0;
    for (int i = 0; i < 60 && busy; i++) begin
      tick;
      if (step_d) nd++;
    end
    chk("ign_cnt", nd, 3);
    chk("idle_c", busy, 0);
    ack = 0;
    clear_int;
    // reset in WAIT
    go = 1; src_en = 1; count = 1;
    tick;
    go = 0; src_en = 0;
    tick;
    tick;
    chk("pre_rst", {mreq, read, phase}, 4'b0101);
    xreset_n = 0; ack = 1;
    tick;
    chk("rst_mid", {wv, o}, 0);
    xreset_n = 1;
    tick;
    chk("post_rst", {step_s, step_d, mreq, blit_breq_0, busy}, 0);
    ack = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/blit_bus_seq.md
# blit_bus_seq

Bus-cycle sequencer for the Tom blitter. It takes a start command from the GPU register decode, then requests the system bus through the blitter bus-request lines and waits for the grant. For each pixel-word it issues the source-read, destination-read and destination-write memory cycles in order, and raises the blitter interrupt when the count is exhausted. It sits between the blitter register file and address generators on one side, and the memory controller handshake (mreq/read/width/ack) on the other.

## Interface
- CW, 16, width of the pixel-word count
- sys_clk  in  1  system clock; all logic on rising edge
- xreset_n  in  1  reset, synchronous, active-low
- go  in  1  one-cycle start pulse (GPU write to command register)
- src_en  in  1  command includes source read phase; latched on accepted go
- dsten  in  1  command includes destination read phase; latched on accepted go
- busprio  in  1  high-priority bus request; latched on accepted go
- cmd_width  in  4  memory cycle width code; latched on accepted go
- count  in  CW  pixel-words to process; latched on accepted go
- int_clr  in  1  clears blit_int
- blit_back  in  1  bus grant from arbiter
- ack  in  1  memory controller cycle acknowledge
- blit_breq_0  out  1  bus request
- blit_breq_1  out  1  bus request priority (= latched busprio while requesting)
- mreq  out  1  memory cycle start, one-cycle pulse
- read  out  1  1 = read cycle, 0 = write; valid with mreq and until ack
- width_0..width_3  out  1 each  latched cmd_width, bit 0 = LSB
- phase  out  2  current access: 0 none, 1 source read, 2 dest read, 3 dest write
- step_s  out  1  one-cycle pulse on source-read ack (advance source address)
- step_d  out  1  one-cycle pulse on dest-write ack (advance dest address)
- busy  out  1  command in progress
- blit_int  out  1  sticky completion interrupt

## Operation
- States: IDLE, REQ, ISSUE, WAIT, DONE. Phase register selects SRC / DRD / DWR. Remaining-count register is CW bits.
- IDLE:
  - go accepted → latch inputs, busy=1.
  - count≠0 → REQ, with first phase = SRC if src_en, else DRD if dsten, else DWR.
  - count=0 → DONE without requesting the bus.
- REQ: blit_breq_0=1. When blit_back=1 → ISSUE.
- ISSUE: mreq=1 for this single cycle, read=1 for SRC/DRD and 0 for DWR → WAIT.
- WAIT: mreq=0, read held. On ack:
  - SRC → step_s; next phase DRD if dsten, else DWR.
  - DRD → next phase DWR.
  - DWR → step_d; count−1. If the result is 0 → DONE, else next phase = first phase.
  - If the next access exists and blit_back=1 → ISSUE, else → REQ.
- blit_breq_0 stays high in REQ/ISSUE/WAIT. It is never dropped between accesses of one command.
- DONE: one cycle. breq low, busy low on exit, blit_int set → IDLE.
- go while busy=1 is ignored; no latching occurs.
- blit_int: set in DONE, cleared by int_clr. If set and clear occur in the same cycle, set wins.
- ack outside WAIT is ignored.
- blit_back dropping during WAIT does not abort the outstanding cycle. It only gates the next ISSUE.

## Timing
- Reset values (xreset_n=0 at the edge), independent of state, including mid-command: state IDLE, count 0, and all outputs 0: blit_breq_0/1, mreq, read, width, phase, step_s, step_d, busy, blit_int. Any outstanding cycle is abandoned.
- All outputs are registered.
- go at edge n → busy=1 and blit_breq_0=1 at n+1.
- blit_back sampled high at edge k in REQ → mreq=1 during k+1.
- ack sampled at edge j in WAIT:
  - step pulse during j+1.
  - Next mreq during j+1 if blit_back=1 at j.
  - Minimum access period is 2 cycles.
- Final DWR ack at j → DONE during j+1 → busy=0, breq=0, blit_int=1 from j+2.
- phase is valid from the ISSUE cycle through the ack cycle, and 0 in IDLE/DONE.

## Test plan
- count=2, src_en=1, dsten=0, blit_back tied 1, ack 1 cycle after each mreq:
  - mreq sequence R,W,R,W.
  - 2 step_s and 2 step_d pulses.
  - blit_int rises 2 cycles after the 4th ack.
- count=1, src_en=1, dsten=1, busprio=1:
  - blit_breq_1=1 throughout.
  - Phases 1,2,3 each with one mreq.
  - read = 1,1,0.
- blit_back held low 5 cycles after go:
  - No mreq; breq high.
  - mreq appears 1 cycle after back rises.
  - back drops during WAIT → ack still completes, next mreq waits for back.
- count=0:
  - No breq or mreq ever.
  - busy high for 2 cycles, then blit_int=1.
  - go during busy of a longer command is ignored and the count is unchanged.
- Reset asserted in WAIT mid-command → all outputs 0 next cycle; a later ack causes no step pulse.
- int_clr coincident with DONE → blit_int=1; int_clr next cycle → 0.
